// File: rtl/vga_stream_encoder.sv
// VGA raster generator fed by an RGB444 AXI-stream, locking to tuser at the raster origin.
// Optional 2x pixel-doubling upscaler is enabled by defining VGA_STREAM_PIXEL_DOUBLE_EN.
module vga_stream_encoder #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0
) (
    input  logic        oclk,
    input  logic        resetn,
    input  logic        in_axis_tvalid,
    output logic        in_axis_tready,
    input  logic [11:0] in_axis_tdata,
    input  logic        in_axis_tuser,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        vga_de,
    output logic        frame_start,
    output logic        underflow,
    output logic        sof_err,
    output logic        locked,
    input  logic        clr_status,
    output logic        fsm_state
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam logic HS_ON = (HSYNC_POL != 0);
    localparam logic VS_ON = (VSYNC_POL != 0);

    typedef enum logic {WAIT_SOF = 1'b0, RUN = 1'b1} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          active;
    logic          origin;
    logic          slot;
    logic          hsync_win;
    logic          vsync_win;
    logic          show_pix;
    logic          uf_set;
    logic          se_set;
    logic [11:0]   pix;
    logic [11:0]   rgb_nxt;

    // Raster counters free-run independently of the stream.
    always_ff @(posedge oclk) begin
        if (!resetn) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == HW'(H_TOTAL - 1)) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    assign active    = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
    assign origin    = (h_cnt == '0) && (v_cnt == '0);
    assign hsync_win = (h_cnt >= HW'(H_ACTIVE + H_FP)) && (h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC));
    assign vsync_win = (v_cnt >= VW'(V_ACTIVE + V_FP)) && (v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC));

    always_ff @(posedge oclk) begin
        if (!resetn) state <= WAIT_SOF;
        else         state <= state_nxt;
    end

    // slot marks cycles on which RUN must consume a pixel; a missing or early-SOF pixel there drops lock.
    always_comb begin
        state_nxt = state;
        uf_set    = 1'b0;
        se_set    = 1'b0;
        case (state)
            WAIT_SOF: if (origin && in_axis_tvalid && in_axis_tuser) state_nxt = RUN;
            RUN: if (slot) begin
                if (!in_axis_tvalid) begin
                    uf_set    = 1'b1;
                    state_nxt = WAIT_SOF;
                end else if (in_axis_tuser && !origin) begin
                    se_set    = 1'b1;
                    state_nxt = WAIT_SOF;
                end
            end
            default: state_nxt = WAIT_SOF;
        endcase
    end

    // Handshake: a pixel transfers on a cycle with tvalid && tready; tready depends only on
    // tvalid/tuser, the FSM state and the raster position, and the source must hold its word until then.
    always_comb begin
        in_axis_tready = 1'b0;
        show_pix       = 1'b0;
        case (state)
            WAIT_SOF: begin
                in_axis_tready = in_axis_tvalid && (!in_axis_tuser || origin);
                show_pix       = origin && in_axis_tvalid && in_axis_tuser;
            end
            RUN: begin
                in_axis_tready = slot && in_axis_tvalid && !(in_axis_tuser && !origin);
                show_pix       = in_axis_tready;
            end
            default: begin
                in_axis_tready = 1'b0;
                show_pix       = 1'b0;
            end
        endcase
    end

    assign pix = show_pix ? in_axis_tdata : 12'h000;

`ifdef VGA_STREAM_PIXEL_DOUBLE_EN
    localparam int LB_W = $clog2(H_ACTIVE / 2);

    logic [11:0]     linebuf [H_ACTIVE/2];
    logic [LB_W-1:0] lb_idx;

    // Even lines fill the buffer with whatever was shown; odd columns and odd lines replay it.
    assign lb_idx = h_cnt[LB_W:1];
    assign slot   = active && !v_cnt[0] && !h_cnt[0];

    always_ff @(posedge oclk) begin
        if (slot) linebuf[lb_idx] <= pix;
    end

    always_comb begin
        rgb_nxt = 12'h000;
        if (slot)        rgb_nxt = pix;
        else if (active) rgb_nxt = linebuf[lb_idx];
    end
`else
    assign slot    = active;
    assign rgb_nxt = pix;
`endif

    always_ff @(posedge oclk) begin
        if (!resetn) begin
            {vga_r, vga_g, vga_b} <= '0;
            vga_de      <= 1'b0;
            vga_hsync   <= !HS_ON;
            vga_vsync   <= !VS_ON;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
            sof_err     <= 1'b0;
        end else begin
            {vga_r, vga_g, vga_b} <= rgb_nxt;
            vga_de      <= active;
            vga_hsync   <= hsync_win ? HS_ON : !HS_ON;
            vga_vsync   <= vsync_win ? VS_ON : !VS_ON;
            frame_start <= origin;
            if (clr_status)  underflow <= 1'b0;
            else if (uf_set) underflow <= 1'b1;
            if (clr_status)  sof_err <= 1'b0;
            else if (se_set) sof_err <= 1'b1;
        end
    end

    assign locked    = (state == RUN);
    assign fsm_state = state;
endmodule

// File: tb/tb_vga_stream_encoder.sv
// Bench for vga_stream_encoder: reference raster model feeding an expected-output queue,
// table of stream scenarios with expected sticky-flag outcomes, plus a mid-frame reset sequence.
`timescale 1ns/1ps
module tb_vga_stream_encoder;
    localparam int H_ACTIVE = 8;
    localparam int H_FP     = 2;
    localparam int H_SYNC   = 2;
    localparam int H_BP     = 2;
    localparam int V_ACTIVE = 4;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 1;
    localparam int V_BP     = 1;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME_CYC = H_TOTAL * V_TOTAL;
    localparam int W = 19;
`ifdef VGA_STREAM_PIXEL_DOUBLE_EN
    localparam int FRAME_PIX = (H_ACTIVE / 2) * (V_ACTIVE / 2);
    localparam int DROP_LEN  = 2;
`else
    localparam int FRAME_PIX = H_ACTIVE * V_ACTIVE;
    localparam int DROP_LEN  = 1;
`endif

    logic        oclk = 1'b0;
    logic        resetn = 1'b0;
    logic        tvalid = 1'b0;
    logic        tready;
    logic [11:0] tdata = '0;
    logic        tuser = 1'b0;
    logic        clr_status = 1'b0;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        hs, vs, de, fs, uf, se, locked, fsm_state;

    vga_stream_encoder #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HSYNC_POL(0), .VSYNC_POL(0)
    ) dut (
        .oclk(oclk), .resetn(resetn),
        .in_axis_tvalid(tvalid), .in_axis_tready(tready),
        .in_axis_tdata(tdata), .in_axis_tuser(tuser),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hsync(hs), .vga_vsync(vs), .vga_de(de),
        .frame_start(fs), .underflow(uf), .sof_err(se), .locked(locked),
        .clr_status(clr_status), .fsm_state(fsm_state)
    );

    always #5 oclk = ~oclk;

    logic [W-1:0] exp_q[$];
    logic [12:0]  src_q[$];
    int checks = 0;
    int passed = 0;
    int drop_data = -1;
    int drop_cnt = 0;
    int de_cnt = 0;
    int fs_cnt = 0;

    // Reference model state: raster position of the next driven cycle, lock state, sticky flags.
    int bh = 0;
    int bv = 0;
    bit bst = 1'b0;
    bit b_uf = 1'b0;
    bit b_se = 1'b0;
`ifdef VGA_STREAM_PIXEL_DOUBLE_EN
    logic [11:0] lb [H_ACTIVE/2];
`endif

    typedef struct {
        int idle;
        int junk;
        int drop_px;
        int cut_px;
        bit exp_uf;
        bit exp_se;
        bit exp_lock;
    } scen_t;
    scen_t tbl[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic cycle(input bit rst_n, input bit clr);
        logic [W-1:0] e;
        logic [W-1:0] a;
        logic [11:0]  d;
        logic [11:0]  p;
        bit v, u, rdy, act, org, slot, nst, ufs, ses, hs_e, vs_e;
        @(negedge oclk);
        a = {vga_r, vga_g, vga_b, de, hs, vs, fs, uf, se, locked};
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("outputs", a, e);
        end
        de_cnt += int'(de);
        fs_cnt += int'(fs);
        v = (src_q.size() > 0);
        u = 1'b0;
        d = '0;
        if (v) begin
            u = src_q[0][12];
            d = src_q[0][11:0];
        end
        if (v && !u && drop_cnt > 0 && int'(d) == drop_data) begin
            v = 1'b0;
            drop_cnt--;
        end
        resetn = rst_n;
        clr_status = clr;
        tvalid = v;
        tuser = u;
        tdata = d;
        #1;
        rdy = 1'b0;
        if (!rst_n) begin
            e = {12'h000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
            bh = 0; bv = 0; bst = 1'b0; b_uf = 1'b0; b_se = 1'b0;
        end else begin
            act = (bh < H_ACTIVE) && (bv < V_ACTIVE);
            org = (bh == 0) && (bv == 0);
`ifdef VGA_STREAM_PIXEL_DOUBLE_EN
            slot = act && (bv % 2 == 0) && (bh % 2 == 0);
`else
            slot = act;
`endif
            p = '0; nst = bst; ufs = 1'b0; ses = 1'b0;
            if (!bst) begin
                rdy = v && (!u || org);
                if (org && v && u) begin p = d; nst = 1'b1; end
            end else if (slot) begin
                if (!v) begin ufs = 1'b1; nst = 1'b0; end
                else if (u && !org) begin ses = 1'b1; nst = 1'b0; end
                else begin rdy = 1'b1; p = d; end
            end
`ifdef VGA_STREAM_PIXEL_DOUBLE_EN
            if (slot) lb[bh/2] = p;
            else if (act) p = lb[bh/2];
`endif
            b_uf = clr ? 1'b0 : (b_uf | ufs);
            b_se = clr ? 1'b0 : (b_se | ses);
            bst = nst;
            hs_e = !((bh >= H_ACTIVE + H_FP) && (bh < H_ACTIVE + H_FP + H_SYNC));
            vs_e = !((bv >= V_ACTIVE + V_FP) && (bv < V_ACTIVE + V_FP + V_SYNC));
            e = {p, act, hs_e, vs_e, org, b_uf, b_se, bst};
            check("tready", tready, rdy);
            if (bh == H_TOTAL - 1) begin
                bh = 0;
                bv = (bv == V_TOTAL - 1) ? 0 : bv + 1;
            end else begin
                bh++;
            end
        end
        if (rdy) void'(src_q.pop_front());
        exp_q.push_back(e);
    endtask

    task automatic push_frames(input int n, input int cut);
        for (int f = 0; f < n; f++) begin
            int len;
            len = (f == 0 && cut >= 0) ? cut : FRAME_PIX;
            for (int i = 0; i < len; i++) src_q.push_back({(i == 0), 12'(i)});
        end
    endtask

    initial begin
        int n;
`ifdef VGA_STREAM_PIXEL_DOUBLE_EN
        tbl[0] = '{0, 0, -1, -1, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{30, 5, -1, -1, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{0, 0, 5, -1, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{0, 0, -1, 6, 1'b0, 1'b1, 1'b1};
`else
        tbl[0] = '{0, 0, -1, -1, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{30, 5, -1, -1, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{0, 0, 13, -1, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{0, 0, -1, 20, 1'b0, 1'b1, 1'b1};
`endif
        repeat (3) cycle(1'b0, 1'b0);
        check("reset_de", de, 1'b0);
        check("reset_sync", {hs, vs}, 2'b11);
        check("reset_flags", {fs, uf, se, locked}, 4'b0000);

        for (int s = 0; s < 4; s++) begin
            src_q.delete();
            drop_cnt = 0;
            repeat (3) cycle(1'b0, 1'b0);
            for (int i = 0; i < tbl[s].idle; i++) cycle(1'b1, 1'b0);
            for (int j = 0; j < tbl[s].junk; j++) src_q.push_back({1'b0, 12'(100 + j)});
            push_frames(4, tbl[s].cut_px);
            drop_data = tbl[s].drop_px;
            drop_cnt = (tbl[s].drop_px >= 0) ? DROP_LEN : 0;
            de_cnt = 0;
            fs_cnt = 0;
            for (int i = 0; i < 3 * FRAME_CYC; i++) cycle(1'b1, 1'b0);
            check($sformatf("scen%0d_underflow", s), uf, tbl[s].exp_uf);
            check($sformatf("scen%0d_sof_err", s), se, tbl[s].exp_se);
            check($sformatf("scen%0d_locked", s), locked, tbl[s].exp_lock);
            check($sformatf("scen%0d_fsm_state", s), fsm_state, tbl[s].exp_lock);
            if (s == 0) begin
                check("de_count_3_frames", de_cnt, 3 * H_ACTIVE * V_ACTIVE);
                check("frame_start_count", fs_cnt, 3);
            end
            cycle(1'b1, 1'b1);
            cycle(1'b1, 1'b0);
            check($sformatf("scen%0d_cleared", s), {uf, se}, 2'b00);
        end

        // Reset pulse while locked and showing (4,2); outputs return to reset values, raster restarts.
        src_q.delete();
        drop_cnt = 0;
        repeat (3) cycle(1'b0, 1'b0);
        push_frames(3, -1);
        n = 0;
        while (!(bh == 5 && bv == 2) && n < 4 * FRAME_CYC) begin
            cycle(1'b1, 1'b0);
            n++;
        end
        if (n >= 4 * FRAME_CYC) begin
            checks++;
            $display("FAIL midreset_wait: got timeout expected h=5 v=2");
        end
        check("pre_reset_locked", locked, 1'b1);
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        check("midreset_rgb", {vga_r, vga_g, vga_b}, 12'h000);
        check("midreset_de_sync", {de, hs, vs}, 3'b011);
        check("midreset_locked", {locked, fs}, 2'b00);
        cycle(1'b1, 1'b0);
        check("restart_frame_start", fs, 1'b1);
        for (int i = 0; i < 2 * FRAME_CYC; i++) cycle(1'b1, 1'b0);

        @(negedge oclk);
        while (exp_q.size() > 0) begin
            check("outputs_tail", {vga_r, vga_g, vga_b, de, hs, vs, fs, uf, se, locked}, exp_q.pop_front());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
